// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// flush/hold control and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic            mem_read2,
    input  logic [1:0]      rf_sel,
    input  logic [3:0]      alu_fun,
    input  logic            alu_srca,
    input  logic [1:0]      alu_srcb,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1,
    input  logic [XLEN-1:0] id_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd_addr,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            flush,
    input  logic            hold,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic            ex_mem_read2,
    output logic [1:0]      ex_rf_sel,
    output logic [3:0]      ex_alu_fun,
    output logic            ex_alu_srca,
    output logic [1:0]      ex_alu_srcb,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd_addr,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic            stall_id,
    output logic [15:0]     bubble_cnt
);
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            mem_read2;
        logic [1:0]      rf_sel;
        logic [3:0]      alu_fun;
        logic            alu_srca;
        logic [1:0]      alu_srcb;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd_addr;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
    } ex_t;

    ex_t         ex_q, ex_d, id_in;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard, load_bubble;

    always_comb begin
        id_in = '{valid: 1'b1, reg_write: reg_write, mem_write: mem_write,
                  mem_read2: mem_read2, rf_sel: rf_sel, alu_fun: alu_fun,
                  alu_srca: alu_srca, alu_srcb: alu_srcb, pc: id_pc,
                  rs1: id_rs1, rs2: id_rs2, imm: id_imm, rd_addr: id_rd_addr,
                  rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr};
        // an invalid decode slot is captured as an all-zero bubble
        if (!id_valid) id_in = '0;
        hazard = ex_q.valid & ex_q.mem_read2 & id_valid & (ex_q.rd_addr != 5'd0) &
                 ((id_uses_rs1 & (id_rs1_addr == ex_q.rd_addr)) |
                  (id_uses_rs2 & (id_rs2_addr == ex_q.rd_addr)));
        load_bubble = flush | (~hold & hazard);
        ex_d = flush ? '0 : hold ? ex_q : hazard ? '0 : id_in;
        cnt_d = (load_bubble && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_id     = hazard & ~flush & ~hold;
    assign bubble_cnt   = cnt_q;
    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_mem_read2 = ex_q.mem_read2;
    assign ex_rf_sel    = ex_q.rf_sel;
    assign ex_alu_fun   = ex_q.alu_fun;
    assign ex_alu_srca  = ex_q.alu_srca;
    assign ex_alu_srcb  = ex_q.alu_srcb;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_imm       = ex_q.imm;
    assign ex_rd_addr   = ex_q.rd_addr;
    assign ex_rs1_addr  = ex_q.rs1_addr;
    assign ex_rs2_addr  = ex_q.rs2_addr;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, hazard stall,
// flush/hold priority, bubble counter saturation and async reset.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, reg_write, mem_write, mem_read2;
    logic [1:0]  rf_sel, alu_srcb;
    logic [3:0]  alu_fun;
    logic        alu_srca;
    logic [31:0] id_pc, id_rs1, id_rs2, id_imm;
    logic [4:0]  id_rd_addr, id_rs1_addr, id_rs2_addr;
    logic        id_uses_rs1, id_uses_rs2, flush, hold;
    logic        ex_valid, ex_reg_write, ex_mem_write, ex_mem_read2;
    logic [1:0]  ex_rf_sel, ex_alu_srcb;
    logic [3:0]  ex_alu_fun;
    logic        ex_alu_srca;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic        stall_id;
    logic [15:0] bubble_cnt;
    int          checks = 0;
    int          errors = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .reg_write(reg_write),
        .mem_write(mem_write), .mem_read2(mem_read2), .rf_sel(rf_sel),
        .alu_fun(alu_fun), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
        .id_rd_addr(id_rd_addr), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_mem_read2(ex_mem_read2), .ex_rf_sel(ex_rf_sel), .ex_alu_fun(ex_alu_fun),
        .ex_alu_srca(ex_alu_srca), .ex_alu_srcb(ex_alu_srcb), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .stall_id(stall_id),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic rw, input logic mw, input logic mr,
                          input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                          input logic u1, input logic u2, input logic [31:0] pc);
        id_valid = v; reg_write = rw; mem_write = mw; mem_read2 = mr;
        id_rd_addr = rd; id_rs1_addr = a1; id_rs2_addr = a2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_pc = pc;
        id_rs1 = pc + 32'h11; id_rs2 = pc + 32'h22; id_imm = pc + 32'h33;
        rf_sel = 2'd1; alu_fun = 4'd0; alu_srca = 1'b1; alu_srcb = 2'd2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        set_id(1, 1, 0, 0, 5'd5, 5'd1, 5'd2, 1, 1, 32'h1000);
        #12;
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_stall", stall_id, 0);
        chk("rst_pc", ex_pc, 0);
        rst_n = 1'b1;
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd_addr, 5);
        chk("add_rw", ex_reg_write, 1);
        chk("add_pc", ex_pc, 32'h1000);
        chk("add_imm", ex_imm, 32'h1033);
        chk("add_srcb", ex_alu_srcb, 2);
        chk("add_cnt", bubble_cnt, 0);
        // load into EX, then dependent add in ID
        set_id(1, 1, 0, 1, 5'd7, 5'd1, 5'd3, 1, 0, 32'h1004);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd1, 5'd7, 1, 1, 32'h1008);
        #1;
        chk("lu_stall", stall_id, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_rd", ex_rd_addr, 0);
        chk("lu_bub_cnt", bubble_cnt, 1);
        chk("lu_bub_stall", stall_id, 0);
        tick();
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_pc", ex_pc, 32'h1008);
        chk("lu_cap_rs2a", ex_rs2_addr, 7);
        // load to x0: no hazard
        set_id(1, 1, 0, 1, 5'd0, 5'd1, 5'd3, 1, 0, 32'h100c);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd1, 5'd0, 0, 1, 32'h1010);
        #1;
        chk("x0_stall", stall_id, 0);
        tick();
        chk("x0_valid", ex_valid, 1);
        chk("x0_pc", ex_pc, 32'h1010);
        chk("x0_cnt", bubble_cnt, 1);
        // rs1 match matters only when the source is used
        set_id(1, 1, 0, 1, 5'd7, 5'd1, 5'd3, 1, 0, 32'h1014);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd7, 5'd7, 1, 0, 32'h1018);
        #1;
        chk("rs1_stall", stall_id, 1);
        id_uses_rs1 = 1'b0;
        #1;
        chk("nouse_stall", stall_id, 0);
        tick();
        chk("nouse_pc", ex_pc, 32'h1018);
        chk("nouse_cnt", bubble_cnt, 1);
        // store held for 3 cycles
        set_id(1, 0, 1, 0, 5'd0, 5'd2, 5'd4, 1, 1, 32'h2000);
        tick();
        hold = 1'b1;
        set_id(1, 1, 0, 0, 5'd3, 5'd1, 5'd1, 1, 1, 32'h3000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc", ex_pc, 32'h2000);
            chk("hold_mw", ex_mem_write, 1);
            chk("hold_rs2", ex_rs2, 32'h2022);
            chk("hold_stall", stall_id, 0);
            chk("hold_cnt", bubble_cnt, 1);
        end
        // hazard masked by hold, then flush wins over hold
        hold = 1'b0;
        set_id(1, 1, 0, 1, 5'd8, 5'd1, 5'd3, 1, 0, 32'h4000);
        tick();
        hold = 1'b1;
        set_id(1, 1, 0, 0, 5'd9, 5'd8, 5'd1, 1, 0, 32'h4004);
        #1;
        chk("hold_hz_stall", stall_id, 0);
        tick();
        chk("hold_hz_pc", ex_pc, 32'h4000);
        chk("hold_hz_cnt", bubble_cnt, 1);
        flush = 1'b1;
        #1;
        chk("fl_stall", stall_id, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_pc", ex_pc, 0);
        chk("fl_cnt", bubble_cnt, 2);
        flush = 1'b0; hold = 1'b0;
        // invalid ID captured as bubble, not counted
        set_id(0, 1, 1, 1, 5'd6, 5'd1, 5'd3, 1, 1, 32'h5000);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_rw", ex_reg_write, 0);
        chk("inv_pc", ex_pc, 0);
        chk("inv_cnt", bubble_cnt, 2);
        // async reset mid-stall
        set_id(1, 1, 0, 1, 5'd7, 5'd1, 5'd3, 1, 0, 32'h6000);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd7, 5'd1, 1, 0, 32'h6004);
        #1;
        chk("pre_rst_stall", stall_id, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_pc", ex_pc, 0);
        chk("arst_cnt", bubble_cnt, 0);
        chk("arst_stall", stall_id, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_pc", ex_pc, 32'h6004);
        chk("post_rst_cnt", bubble_cnt, 0);
        // saturation
        flush = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", bubble_cnt, 16'hFFFE);
        tick();
        tick();
        chk("sat_ffff", bubble_cnt, 16'hFFFF);
        tick();
        chk("sat_hold", bubble_cnt, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC and operand fields.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 ID_VALID  in  1  decode stage holds a real instruction.
REQ-005 REG_WRITE, MEM_WRITE, MEM_READ2  in  1 each  decoded enables from the control unit.
REQ-006 RF_SEL  in  2; ALU_FUN  in  4; ALU_SRCA  in  1; ALU_SRCB  in  2  decoded selectors.
REQ-007 ID_PC, ID_RS1, ID_RS2, ID_IMM  in  XLEN each  decode-stage PC, register-file operands, immediate.
REQ-008 ID_RD_ADDR, ID_RS1_ADDR, ID_RS2_ADDR  in  5 each  register addresses.
REQ-009 ID_USES_RS1, ID_USES_RS2  in  1 each  instruction reads that source.
REQ-010 FLUSH  in  1  branch/jump redirect; kill instruction entering EX.
REQ-011 HOLD  in  1  downstream stall; freeze EX register.
REQ-012 EX_* outputs  out  same widths as REQ-004..REQ-008 inputs (EX_VALID, EX_REG_WRITE, ..., EX_RS2_ADDR)  registered EX-stage copy.
REQ-013 STALL_ID  out  1  combinational load-use stall request to PC and IF/ID register.
REQ-014 BUBBLE_CNT  out  16  saturating count of bubbles inserted.

Function
REQ-015 Bubble = EX_VALID, all EX control enables/selectors and all EX data/address fields driven to 0.
REQ-016 Load-use hazard = EX_VALID & EX_MEM_READ2 & ID_VALID & (EX_RD_ADDR != 0) & ((ID_USES_RS1 & ID_RS1_ADDR == EX_RD_ADDR) | (ID_USES_RS2 & ID_RS2_ADDR == EX_RD_ADDR)).
REQ-017 STALL_ID = hazard & ~FLUSH & ~HOLD, purely combinational, same cycle.
REQ-018 Per rising edge, priority order: FLUSH -> load bubble; else HOLD -> retain all EX contents; else hazard -> load bubble; else capture all ID inputs.
REQ-019 Captured control fields with ID_VALID=0 are forced to 0 (invalid ID captured as bubble).
REQ-020 Latency: an accepted ID instruction appears on EX_* exactly one cycle after the capturing edge.
REQ-021 A stalled ID instruction is captured on the first edge where hazard clears; at most one bubble per load-use pair (the bubble clears EX_MEM_READ2).
REQ-022 FLUSH and HOLD together: FLUSH wins, bubble loaded.
REQ-023 BUBBLE_CNT increments by 1 on each edge loading a bubble due to FLUSH or hazard; saturates at 0xFFFF; not incremented on HOLD or invalid-ID capture.
REQ-024 Registers are single-stage; no combinational path from ID inputs to EX_* outputs.

Reset
REQ-025 RST_N low asynchronously clears all EX_* outputs and BUBBLE_CNT to 0; state = bubble.
REQ-026 Reset asserted mid-stall discards the held instruction; first edge after RST_N rises captures ID inputs per REQ-018.
REQ-027 STALL_ID is 0 while in reset (EX_VALID=0).

Verification
REQ-028 Add (ALU_FUN=0000, RD=5, ID_VALID=1), no FLUSH/HOLD -> next cycle EX_VALID=1, EX_RD_ADDR=5, EX_REG_WRITE=1, BUBBLE_CNT=0.
REQ-029 EX holds load (MEM_READ2=1, RD=7); ID add with RS2=7, USES_RS2=1 -> STALL_ID=1 same cycle, next cycle EX bubble, BUBBLE_CNT=1, following edge captures add.
REQ-030 Same as REQ-029 but EX_RD_ADDR=0 or USES_RS2=0 -> STALL_ID=0, no bubble.
REQ-031 HOLD=1 for 3 cycles with valid EX store -> EX_* unchanged all 3 cycles; STALL_ID=0; BUBBLE_CNT unchanged.
REQ-032 FLUSH=1 and HOLD=1 same edge -> EX bubble, BUBBLE_CNT +1; 65536 consecutive flushes -> BUBBLE_CNT=0xFFFF.
REQ-033 RST_N pulsed low between clock edges while EX valid -> EX_* and BUBBLE_CNT 0 immediately, without waiting for CLK.
